// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache fill arbiter.
// Holds the FSM state and fill-owner enums plus the block geometry used by
// both the arbiter and its word counters.
package cache_arb_pkg;

  localparam int          BLK_WORDS = 8;             // 16-bit words per cache block
  localparam int          MEM_LAT   = 4;             // memory read latency in cycles
  localparam int          CNT_W     = $clog2(BLK_WORDS);
  localparam logic [15:0] BLK_MASK  = 16'hFFF0;      // clears the in-block byte offset

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_e;

endpackage

// File: rtl/fill_counter.sv
// Block word counter used for both the issue side and the return side of a fill.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clr_i       synchronous clear (wins over enable)
//   en_i        increment; wraps naturally at 2**W
//   cnt_o       current count
//   tc_o        count is at its terminal (all-ones) value
module fill_counter
  import cache_arb_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: next-state is assigned a default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = &cnt_q;

endmodule

// File: rtl/cache_fill_arbiter.sv
// Shares the single main-memory port between the I-cache and D-cache.
// A write-through store is forwarded in one IDLE cycle; a miss is turned into
// an 8-word block read whose returned words are streamed into the owning
// cache's data array, finishing with a one-cycle tag/valid write pulse.
// Ports:
//   i_miss_req/i_miss_addr   I-cache miss (level until i_fill_done)
//   d_miss_req/d_miss_addr   D-cache miss (level until d_fill_done)
//   d_wr_req/addr/data       write-through store (level until d_wr_ack)
//   mem_en/wr/addr/wdata     memory request port (one request per cycle)
//   mem_rdata/mem_rvalid     memory read return
//   fill_i_we/fill_d_we      data-array word write strobes, fill_word/fill_data
//   i_fill_done/d_fill_done  tag write pulse on the last returned word
//   d_wr_ack                 store accepted pulse
module cache_fill_arbiter
  import cache_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_miss_req,
  input  logic [15:0]      i_miss_addr,
  input  logic             d_miss_req,
  input  logic [15:0]      d_miss_addr,
  input  logic             d_wr_req,
  input  logic [15:0]      d_wr_addr,
  input  logic [15:0]      d_wr_data,
  output logic             mem_en,
  output logic             mem_wr,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  input  logic [15:0]      mem_rdata,
  input  logic             mem_rvalid,
  output logic             fill_i_we,
  output logic             fill_d_we,
  output logic [CNT_W-1:0] fill_word,
  output logic [15:0]      fill_data,
  output logic             i_fill_done,
  output logic             d_fill_done,
  output logic             d_wr_ack
);

  state_e      state_q, state_d;
  owner_e      owner_q;
  logic [15:0] base_q;
  logic        i_starved_q;

  logic             grant, grant_i;
  logic             fill_we, last_ret;
  logic [CNT_W-1:0] issue_cnt, ret_cnt;
  logic             issue_tc, ret_tc;

  // D wins by default; I wins only when it has already been passed over once.
  assign grant_i  = i_miss_req && (!d_miss_req || i_starved_q);
  // A pending store takes the IDLE cycle, so the miss waits one cycle behind it.
  assign grant    = (state_q == IDLE) && !d_wr_req && (i_miss_req || d_miss_req);
  // Returns outside a fill (e.g. in flight across a reset) are dropped.
  assign fill_we  = (state_q != IDLE) && mem_rvalid;
  assign last_ret = fill_we && ret_tc;

  fill_counter #(.W(CNT_W)) u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (grant),
    .en_i  (state_q == ISSUE),
    .cnt_o (issue_cnt),
    .tc_o  (issue_tc)
  );

  fill_counter #(.W(CNT_W)) u_ret_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (grant),
    .en_i  (fill_we),
    .cnt_o (ret_cnt),
    .tc_o  (ret_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant) state_d = ISSUE;
      ISSUE:   if (last_ret) state_d = IDLE;
               else if (issue_tc) state_d = DRAIN;
      DRAIN:   if (last_ret) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Owner, block base and the anti-starvation flag only change on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= OWN_I;
      base_q      <= '0;
      i_starved_q <= 1'b0;
    end else if (grant) begin
      owner_q     <= grant_i ? OWN_I : OWN_D;
      base_q      <= (grant_i ? i_miss_addr : d_miss_addr) & BLK_MASK;
      i_starved_q <= grant_i ? 1'b0 : i_miss_req;
    end
  end

  always_comb begin
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    d_wr_ack    = 1'b0;
    fill_i_we   = 1'b0;
    fill_d_we   = 1'b0;
    fill_word   = '0;
    fill_data   = '0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;

    // The store path is combinational from the request, so it is held off
    // while reset is asserted to keep every output at 0.
    if (state_q == IDLE && d_wr_req && rst_n) begin
      mem_en    = 1'b1;
      mem_wr    = 1'b1;
      mem_addr  = d_wr_addr;
      mem_wdata = d_wr_data;
      d_wr_ack  = 1'b1;
    end

    if (state_q == ISSUE) begin
      mem_en   = 1'b1;
      mem_addr = base_q + {{(15 - CNT_W){1'b0}}, issue_cnt, 1'b0};
    end

    if (fill_we) begin
      fill_i_we   = (owner_q == OWN_I);
      fill_d_we   = (owner_q == OWN_D);
      fill_word   = ret_cnt;
      fill_data   = mem_rdata;
      i_fill_done = last_ret && (owner_q == OWN_I);
      d_fill_done = last_ret && (owner_q == OWN_D);
    end
  end

endmodule
